// File: rtl/register_file_dp.sv
// Dual-write, dual-read architectural register file with a per-register pending-write
// scoreboard, valid/ready read handshake, registered read data and writeback bypass.
module register_file_dp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        write,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wr1,
    input  logic [ADDR_W-1:0] wa2,
    input  logic [DATA_W-1:0] wr2,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rd_out_valid,
    input  logic              lock_en,
    input  logic [ADDR_W-1:0] lock_addr,
    output logic              busy
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  lock_q, lock_d;
    logic [NREGS-1:0]  wr_clr, lock_set, eff_lock;
    logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
    logic              rd_out_valid_q;
    logic              accept;

    // Writeback targets this cycle; they release locks and feed the bypass.
    always_comb begin
        wr_clr = '0;
        if (write[0]) wr_clr[wa1] = 1'b1;
        if (write[1]) wr_clr[wa2] = 1'b1;
        lock_set = '0;
        lock_set[lock_addr] = lock_en;
    end

    assign eff_lock = lock_q & ~wr_clr;
    assign rd_ready = ~(eff_lock[ra1] | eff_lock[ra2]);
    assign accept   = rd_valid & rd_ready;

    // A new producer supersedes a writeback to the same register.
    assign lock_d = (lock_q & ~wr_clr) | lock_set;

    always_comb begin
        regs_d = regs_q;
        if (write[0]) regs_d[wa1] = wr1;
        if (write[1]) regs_d[wa2] = wr2;
    end

    // Bypass priority: port 2 write, then port 1 write, then stored value.
    always_comb begin
        rd1_d = rd1_q;
        rd2_d = rd2_q;
        if (accept) begin
            rd1_d = regs_q[ra1];
            if (write[0] && wa1 == ra1) rd1_d = wr1;
            if (write[1] && wa2 == ra1) rd1_d = wr2;
            rd2_d = regs_q[ra2];
            if (write[0] && wa1 == ra2) rd2_d = wr1;
            if (write[1] && wa2 == ra2) rd2_d = wr2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
            lock_q         <= '0;
            rd1_q          <= '0;
            rd2_q          <= '0;
            rd_out_valid_q <= 1'b0;
        end else begin
            regs_q         <= regs_d;
            lock_q         <= lock_d;
            rd1_q          <= rd1_d;
            rd2_q          <= rd2_d;
            rd_out_valid_q <= accept;
        end
    end

    assign rd1          = rd1_q;
    assign rd2          = rd2_q;
    assign rd_out_valid = rd_out_valid_q;
    assign busy         = |lock_q;

endmodule

// File: tb/tb_register_file_dp.sv
// Self-checking bench for register_file_dp: a behavioural model predicts ready/lock state and
// pushes expected read data into a queue that is popped when the DUT reports valid data.
module tb_register_file_dp;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREGS  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        write;
    logic [ADDR_W-1:0] wa1, wa2, ra1, ra2, lock_addr;
    logic [DATA_W-1:0] wr1, wr2;
    logic              rd_valid, lock_en;
    logic              rd_ready, rd_out_valid, busy;
    logic [DATA_W-1:0] rd1, rd2;

    register_file_dp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .write        (write),
        .wa1          (wa1),
        .wr1          (wr1),
        .wa2          (wa2),
        .wr2          (wr2),
        .rd_valid     (rd_valid),
        .ra1          (ra1),
        .ra2          (ra2),
        .rd_ready     (rd_ready),
        .rd1          (rd1),
        .rd2          (rd2),
        .rd_out_valid (rd_out_valid),
        .lock_en      (lock_en),
        .lock_addr    (lock_addr),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] m_regs [NREGS];
    logic [NREGS-1:0]  m_lock;
    logic [DATA_W-1:0] m_rd1, m_rd2;
    logic [2*DATA_W-1:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic m_eff_lock(input logic [ADDR_W-1:0] a);
        return m_lock[a] && !(write[0] && wa1 == a) && !(write[1] && wa2 == a);
    endfunction

    function automatic logic [DATA_W-1:0] m_byp(input logic [ADDR_W-1:0] a);
        if (write[1] && wa2 == a) return wr2;
        if (write[0] && wa1 == a) return wr1;
        return m_regs[a];
    endfunction

    task automatic idle();
        rst = 1'b0; write = 2'b00; wa1 = '0; wa2 = '0; wr1 = '0; wr2 = '0;
        rd_valid = 1'b0; ra1 = '0; ra2 = '0; lock_en = 1'b0; lock_addr = '0;
    endtask

    // One clock: check ready before the edge, update model at the edge, check outputs after.
    task automatic step();
        logic exp_ready, acc;
        #1;
        exp_ready = !(m_eff_lock(ra1) || m_eff_lock(ra2));
        check("rd_ready", {63'd0, rd_ready}, {63'd0, exp_ready});
        acc = rd_valid && exp_ready && !rst;
        if (acc) exp_q.push_back({m_byp(ra1), m_byp(ra2)});
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
            m_lock = '0;
            m_rd1  = '0;
            m_rd2  = '0;
            exp_q.delete();
        end else begin
            if (write[0]) begin m_regs[wa1] = wr1; m_lock[wa1] = 1'b0; end
            if (write[1]) begin m_regs[wa2] = wr2; m_lock[wa2] = 1'b0; end
            if (lock_en) m_lock[lock_addr] = 1'b1;
        end
        #1;
        if (exp_q.size() != 0) begin
            {m_rd1, m_rd2} = exp_q.pop_front();
            check("rd_out_valid", {63'd0, rd_out_valid}, 64'd1);
        end else begin
            check("rd_out_valid", {63'd0, rd_out_valid}, 64'd0);
        end
        check("rd1", {32'd0, rd1}, {32'd0, m_rd1});
        check("rd2", {32'd0, rd2}, {32'd0, m_rd2});
        check("busy", {63'd0, busy}, {63'd0, |m_lock});
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        m_lock = '0; m_rd1 = '0; m_rd2 = '0;
        check("reset_rd1", {32'd0, rd1}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_valid", {63'd0, rd_out_valid}, 64'd0);

        // Seed a register so the reset-mid-read test has something to clear.
        idle(); write = 2'b01; wa1 = 5'd3; wr1 = 32'hDEAD_BEEF; lock_en = 1'b1; lock_addr = 5'd20;
        step();
        idle(); rst = 1'b1; rd_valid = 1'b1; ra1 = 5'd3;
        step();
        check("rst_mid_read_valid", {63'd0, rd_out_valid}, 64'd0);
        idle(); rd_valid = 1'b1; ra1 = 5'd3; ra2 = 5'd20;
        step();
        idle(); step();
        check("rst_readback_r3", {32'd0, rd1}, 64'd0);

        // Dual write then read.
        idle(); write = 2'b11; wa1 = 5'd4; wr1 = 32'hAAAA_0001; wa2 = 5'd5; wr2 = 32'hBBBB_0002;
        step();
        idle(); rd_valid = 1'b1; ra1 = 5'd4; ra2 = 5'd5;
        step();
        check("dual_rd1", {32'd0, rd1}, 64'hAAAA_0001);
        check("dual_rd2", {32'd0, rd2}, 64'hBBBB_0002);

        // Write conflict: port 2 wins.
        idle(); write = 2'b11; wa1 = 5'd7; wa2 = 5'd7; wr1 = 32'd1; wr2 = 32'd2;
        step();
        idle(); rd_valid = 1'b1; ra1 = 5'd7; ra2 = 5'd7;
        step();
        check("conflict_rd1", {32'd0, rd1}, 64'd2);

        // Same-cycle bypass into both ports.
        idle(); write = 2'b01; wa1 = 5'd9; wr1 = 32'h1234; rd_valid = 1'b1; ra1 = 5'd9; ra2 = 5'd9;
        step();
        check("bypass_rd1", {32'd0, rd1}, 64'h1234);
        check("bypass_rd2", {32'd0, rd2}, 64'h1234);

        // Scoreboard stall on r10, released by a port-2 writeback.
        idle(); lock_en = 1'b1; lock_addr = 5'd10;
        step();
        for (int i = 0; i < 3; i++) begin
            idle(); rd_valid = 1'b1; ra1 = 5'd0; ra2 = 5'd10;
            step();
            check("stall_ready", {63'd0, rd_ready}, 64'd0);
        end
        idle(); rd_valid = 1'b1; ra1 = 5'd0; ra2 = 5'd10; write = 2'b10; wa2 = 5'd10; wr2 = 32'h55;
        #1;
        check("release_ready", {63'd0, rd_ready}, 64'd1);
        step();
        check("release_rd2", {32'd0, rd2}, 64'h55);
        check("release_busy", {63'd0, busy}, 64'd0);

        // Lock and clear of the same register in one cycle: lock survives.
        idle(); lock_en = 1'b1; lock_addr = 5'd12; write = 2'b01; wa1 = 5'd12; wr1 = 32'h77;
        step();
        idle(); rd_valid = 1'b1; ra1 = 5'd12; ra2 = 5'd12;
        #1;
        check("lockclr_ready", {63'd0, rd_ready}, 64'd0);
        check("lockclr_busy", {63'd0, busy}, 64'd1);
        step();
        idle(); write = 2'b10; wa2 = 5'd12; wr2 = 32'h88;
        step();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            idle();
            write     = 2'($urandom);
            wa1       = ADDR_W'($urandom_range(0, 15));
            wa2       = ADDR_W'($urandom_range(0, 15));
            wr1       = $urandom;
            wr2       = $urandom;
            rd_valid  = ($urandom_range(0, 3) != 0);
            ra1       = ADDR_W'($urandom_range(0, 15));
            ra2       = ADDR_W'($urandom_range(0, 15));
            lock_en   = ($urandom_range(0, 3) == 0);
            lock_addr = ADDR_W'($urandom_range(0, 15));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
